// File: rtl/frame_dma_pkg.sv
// Shared definitions for the frame DMA scheduler: register map, CTRL bits,
// FSM encoding and the STATUS register layout.
package frame_dma_pkg;

    localparam logic [2:0] REG_CTRL        = 3'd0;
    localparam logic [2:0] REG_BASE        = 3'd1;
    localparam logic [2:0] REG_FRAME_WORDS = 3'd2;
    localparam logic [2:0] REG_NUM_BUFS    = 3'd3;
    localparam logic [2:0] REG_STATUS      = 3'd4;
    localparam logic [2:0] REG_IRQ         = 3'd5;
    localparam logic [2:0] REG_LOCK        = 3'd6;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_LOCK_EN = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOF = 3'd1,
        ST_ARM      = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    typedef struct packed {
        logic [2:0]  cur_buf;
        logic [2:0]  last_buf;
        logic        last_valid;
        state_e      state;
        logic [15:0] drop_cnt;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t s);
        return {s.drop_cnt, 4'b0000, s.state, s.last_valid, 1'b0,
                s.last_buf, 1'b0, s.cur_buf};
    endfunction

endpackage

// File: rtl/frame_dma_sched_if.sv
// CPU-side Wishbone slave bus of the frame DMA scheduler (32-bit data).
interface frame_dma_sched_if;
    logic [4:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
                    input  wbs_dat_o, wbs_ack_o);
    modport slave  (input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
                    output wbs_dat_o, wbs_ack_o);
endinterface

// File: rtl/frame_dma_regs.sv
// Wishbone register file of the frame DMA scheduler: decode, config storage,
// STATUS readback and the frame-done interrupt pending flag.
module frame_dma_regs
    import frame_dma_pkg::*;
#(
    parameter int WB_AW    = 32,
    parameter int WB_DW    = 32,
    parameter int MAX_BUFS = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    frame_dma_sched_if.slave  wbs,
    input  status_t           status_i,
    input  logic              irq_set_i,
    output logic              run_o,
    output logic              lock_en_o,
    output logic [WB_AW-1:0]  base_o,
    output logic [WB_AW-1:0]  frame_words_o,
    output logic [3:0]        num_bufs_o,
    output logic [2:0]        lock_o,
    output logic              irq_o
);

    logic [2:0]       ctrl_q;
    logic [WB_AW-1:0] base_q;
    logic [WB_AW-1:0] fw_q;
    logic [3:0]       nbufs_q;
    logic [2:0]       lock_q;
    logic             pending_q;
    logic             ack_q;
    logic [WB_DW-1:0] dat_q;
    logic [WB_DW-1:0] rd_data;
    logic [2:0]       adr_idx;
    logic             req;
    logic             wr_stb;
    logic             irq_clr;
    logic             unused_adr_bits;

    assign adr_idx         = wbs.wbs_adr_i[4:2];
    assign unused_adr_bits = ^wbs.wbs_adr_i[1:0];
    // One request per ack: the cycle after an ack cannot re-acknowledge.
    assign req     = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q;
    assign wr_stb  = req && wbs.wbs_we_i;
    assign irq_clr = wr_stb && (adr_idx == REG_IRQ) && wbs.wbs_dat_i[0];

    always_comb begin
        // NOTE: default first so every path assigns rd_data and no latch is inferred.
        rd_data = '0;
        case (adr_idx)
            REG_CTRL:        rd_data = WB_DW'(ctrl_q);
            REG_BASE:        rd_data = WB_DW'(base_q);
            REG_FRAME_WORDS: rd_data = WB_DW'(fw_q);
            REG_NUM_BUFS:    rd_data = WB_DW'(nbufs_q);
            REG_STATUS:      rd_data = WB_DW'(pack_status(status_i));
            REG_IRQ:         rd_data = WB_DW'(pending_q);
            REG_LOCK:        rd_data = WB_DW'(lock_q);
            default:         rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl_q    <= '0;
            base_q    <= '0;
            fw_q      <= '0;
            nbufs_q   <= '0;
            lock_q    <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            ack_q <= req;
            if (req) begin
                dat_q <= rd_data;
            end
            if (wr_stb) begin
                case (adr_idx)
                    REG_CTRL:        ctrl_q  <= wbs.wbs_dat_i[2:0];
                    REG_BASE:        base_q  <= WB_AW'(wbs.wbs_dat_i) & ~WB_AW'(3);
                    REG_FRAME_WORDS: fw_q    <= WB_AW'(wbs.wbs_dat_i);
                    REG_NUM_BUFS:    nbufs_q <= wbs.wbs_dat_i[3:0];
                    REG_LOCK:        lock_q  <= wbs.wbs_dat_i[2:0];
                    default:         ;
                endcase
            end
            // A completing frame outranks a simultaneous software clear.
            if (irq_set_i) begin
                pending_q <= 1'b1;
            end else if (irq_clr) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        if (nbufs_q == 4'd0) begin
            num_bufs_o = 4'd1;
        end else if (nbufs_q > 4'(MAX_BUFS)) begin
            num_bufs_o = 4'(MAX_BUFS);
        end else begin
            num_bufs_o = nbufs_q;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign run_o         = ctrl_q[CTRL_RUN];
    assign lock_en_o     = ctrl_q[CTRL_LOCK_EN];
    assign base_o        = base_q;
    assign frame_words_o = fw_q;
    assign lock_o        = lock_q;
    assign irq_o         = pending_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/frame_dma_sched.sv
// Frame buffer scheduler for the Wishbone stream writer: walks a ring of
// frame buffers, arms the writer per frame and counts acks to detect completion.
module frame_dma_sched
    import frame_dma_pkg::*;
#(
    parameter int WB_AW    = 32,
    parameter int WB_DW    = 32,
    parameter int MAX_BUFS = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    frame_dma_sched_if.slave  wbs,
    input  logic              frame_start,
    input  logic              wr_ack,
    output logic              wr_enable,
    output logic [WB_AW-1:0]  wr_start_adr,
    output logic              irq
);

    logic             run;
    logic             lock_en;
    logic [WB_AW-1:0] base;
    logic [WB_AW-1:0] frame_words;
    logic [3:0]       num_bufs;
    logic [2:0]       lock_idx;

    state_e           state_q;
    logic [WB_AW-1:0] cur_adr_q;
    logic [WB_AW-1:0] word_cnt_q;
    logic [WB_AW-1:0] fw_lat_q;
    logic [2:0]       cur_buf_q;
    logic [2:0]       last_buf_q;
    logic             last_valid_q;
    logic             sof_pend_q;
    logic             wr_enable_q;
    logic [15:0]      drop_cnt_q;
    status_t          status;

    logic [WB_AW-1:0] step_bytes;
    logic [WB_AW-1:0] adr1;
    logic [WB_AW-1:0] adr2;
    logic [WB_AW-1:0] adv_adr_d;
    logic [3:0]       nb1;
    logic [3:0]       nb2;
    logic [2:0]       buf1;
    logic [2:0]       buf2;
    logic [2:0]       adv_buf_d;
    logic             skip;

    frame_dma_regs #(
        .WB_AW    (WB_AW),
        .WB_DW    (WB_DW),
        .MAX_BUFS (MAX_BUFS)
    ) u_regs (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .wbs           (wbs),
        .status_i      (status),
        .irq_set_i     ((state_q == ST_DONE) && run),
        .run_o         (run),
        .lock_en_o     (lock_en),
        .base_o        (base),
        .frame_words_o (frame_words),
        .num_bufs_o    (num_bufs),
        .lock_o        (lock_idx),
        .irq_o         (irq)
    );

    assign status = '{cur_buf: cur_buf_q, last_buf: last_buf_q, last_valid: last_valid_q,
                      state: state_q, drop_cnt: drop_cnt_q};

    // Next buffer by accumulation; a locked buffer is stepped over with a second step.
    always_comb begin
        step_bytes = fw_lat_q << 2;
        nb1        = {1'b0, cur_buf_q} + 4'd1;
        adr1       = (nb1 >= num_bufs) ? base : cur_adr_q + step_bytes;
        buf1       = (nb1 >= num_bufs) ? 3'd0 : nb1[2:0];
        nb2        = {1'b0, buf1} + 4'd1;
        adr2       = (nb2 >= num_bufs) ? base : adr1 + step_bytes;
        buf2       = (nb2 >= num_bufs) ? 3'd0 : nb2[2:0];
        skip       = lock_en && (num_bufs >= 4'd3) && (buf1 == lock_idx);
        adv_adr_d  = skip ? adr2 : adr1;
        adv_buf_d  = skip ? buf2 : buf1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            cur_adr_q    <= '0;
            word_cnt_q   <= '0;
            fw_lat_q     <= '0;
            cur_buf_q    <= '0;
            last_buf_q   <= '0;
            last_valid_q <= 1'b0;
            sof_pend_q   <= 1'b0;
            wr_enable_q  <= 1'b0;
            drop_cnt_q   <= '0;
        end else if (!run) begin
            state_q     <= ST_IDLE;
            wr_enable_q <= 1'b0;
            sof_pend_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_words != '0) begin
                        state_q   <= ST_WAIT_SOF;
                        cur_adr_q <= base;
                        cur_buf_q <= '0;
                    end
                end
                ST_WAIT_SOF: begin
                    if (frame_start || sof_pend_q) begin
                        state_q    <= ST_ARM;
                        sof_pend_q <= 1'b0;
                    end
                end
                ST_ARM: begin
                    word_cnt_q  <= '0;
                    fw_lat_q    <= frame_words;
                    wr_enable_q <= 1'b1;
                    state_q     <= ST_RUN;
                    if (frame_start) begin
                        sof_pend_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wr_ack && (word_cnt_q + WB_AW'(1) == fw_lat_q)) begin
                        word_cnt_q  <= word_cnt_q + WB_AW'(1);
                        wr_enable_q <= 1'b0;
                        state_q     <= ST_DONE;
                        if (frame_start) begin
                            sof_pend_q <= 1'b1;
                        end
                    end else if (frame_start) begin
                        // Short frame: rearm the same buffer for the new frame.
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_q <= drop_cnt_q + 16'd1;
                        end
                        wr_enable_q <= 1'b0;
                        state_q     <= ST_ARM;
                    end else if (wr_ack) begin
                        word_cnt_q <= word_cnt_q + WB_AW'(1);
                    end
                end
                ST_DONE: begin
                    last_buf_q   <= cur_buf_q;
                    last_valid_q <= 1'b1;
                    cur_adr_q    <= adv_adr_d;
                    cur_buf_q    <= adv_buf_d;
                    state_q      <= ST_WAIT_SOF;
                    if (frame_start) begin
                        sof_pend_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    wr_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_enable    = wr_enable_q;
    assign wr_start_adr = cur_adr_q;

endmodule

// File: tb/tb_frame_dma_sched.sv
// Directed bench for frame_dma_sched: register table plus hand-sequenced frames.
module tb_frame_dma_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        wr_ack;
    logic        wr_enable;
    logic [31:0] wr_start_adr;
    logic        irq;
    int          n_checks = 0;
    int          n_fail   = 0;

    frame_dma_sched_if bus ();

    frame_dma_sched #(.WB_AW(32), .WB_DW(32), .MAX_BUFS(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wbs          (bus),
        .frame_start  (frame_start),
        .wr_ack       (wr_ack),
        .wr_enable    (wr_enable),
        .wr_start_adr (wr_start_adr),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] A_CTRL = 5'h00, A_BASE = 5'h04, A_FW = 5'h08, A_NB = 5'h0C;
    localparam logic [4:0] A_STAT = 5'h10, A_IRQ = 5'h14, A_LOCK = 5'h18, A_UNMAP = 5'h1C;

    typedef struct packed {
        logic [4:0]  adr;
        logic        we;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int cur, input int last, input int lv,
                                               input int st, input int drop);
        return 32'((drop << 16) | (st << 9) | (lv << 8) | (last << 4) | cur);
    endfunction

    // All bus tasks start and end on a falling edge and leave one idle cycle.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.wbs_adr_i = a; bus.wbs_dat_i = d; bus.wbs_we_i = 1'b1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        bus.wbs_adr_i = a; bus.wbs_we_i = 1'b0;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        @(negedge clk);
        d = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic give_acks(input int n);
        for (int i = 0; i < n; i++) begin
            wr_ack = 1'b1;
            @(negedge clk);
        end
        wr_ack = 1'b0;
    endtask

    // From WAIT_SOF: pulse frame_start, see ARM (enable low) then RUN.
    task automatic start_frame(input logic [31:0] exp_adr);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("arm_wr_enable", 32'(wr_enable), 32'd0);
        @(negedge clk);
        check("run_wr_enable", 32'(wr_enable), 32'd1);
        check("run_start_adr", wr_start_adr, exp_adr);
    endtask

    // Completes the frame; optionally writes IRQ clear during the DONE cycle.
    task automatic finish_frame(input int n_acks, input bit clr_in_done);
        give_acks(n_acks);
        check("done_wr_enable", 32'(wr_enable), 32'd0);
        if (clr_in_done) begin
            bus.wbs_adr_i = A_IRQ; bus.wbs_dat_i = 32'd1; bus.wbs_we_i = 1'b1;
            bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
        end
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] lock_adr [4];
        int          lock_last [4];
        int          lock_cur [4];

        vecs[0]  = '{A_CTRL,  1'b0, 32'h0,        32'h0};
        vecs[1]  = '{A_STAT,  1'b0, 32'h0,        32'h0};
        vecs[2]  = '{A_IRQ,   1'b0, 32'h0,        32'h0};
        vecs[3]  = '{A_BASE,  1'b1, 32'h0000_1003, 32'h0};
        vecs[4]  = '{A_BASE,  1'b0, 32'h0,        32'h0000_1000};
        vecs[5]  = '{A_FW,    1'b1, 32'h4,        32'h0};
        vecs[6]  = '{A_FW,    1'b0, 32'h0,        32'h4};
        vecs[7]  = '{A_NB,    1'b1, 32'h2,        32'h0};
        vecs[8]  = '{A_NB,    1'b0, 32'h0,        32'h2};
        vecs[9]  = '{A_LOCK,  1'b1, 32'h5,        32'h0};
        vecs[10] = '{A_LOCK,  1'b0, 32'h0,        32'h5};
        vecs[11] = '{A_CTRL,  1'b1, 32'hFE,       32'h0};
        vecs[12] = '{A_CTRL,  1'b0, 32'h0,        32'h6};

        lock_adr  = '{32'h1000, 32'h1020, 32'h1000, 32'h1020};
        lock_last = '{0, 2, 0, 2};
        lock_cur  = '{2, 0, 2, 0};

        rst = 1'b1; frame_start = 1'b0; wr_ack = 1'b0;
        bus.wbs_adr_i = '0; bus.wbs_dat_i = '0; bus.wbs_we_i = 1'b0;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_wr_enable", 32'(wr_enable), 32'd0);
        check("reset_start_adr", wr_start_adr, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Register map vectors.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].adr, vecs[i].wdat);
            end else begin
                read_check($sformatf("reg_vec%0d", i), vecs[i].adr, vecs[i].exp);
            end
        end
        read_check("unmapped_read", A_UNMAP, 32'h0);
        bus_write(A_CTRL, 32'h0);

        // Two-buffer ring with IRQ set/clear interplay.
        bus_write(A_BASE, 32'h1000);
        bus_write(A_FW, 32'd4);
        bus_write(A_NB, 32'd2);
        bus_write(A_CTRL, 32'h3);
        check("wait_sof_adr", wr_start_adr, 32'h1000);
        start_frame(32'h1000);
        finish_frame(4, 1'b0);
        check("irq_after_frame1", 32'(irq), 32'd1);
        read_check("status_frame1", A_STAT, exp_status(1, 0, 1, 1, 0));
        start_frame(32'h1010);
        finish_frame(4, 1'b1);
        check("irq_set_wins", 32'(irq), 32'd1);
        read_check("status_frame2", A_STAT, exp_status(0, 1, 1, 1, 0));
        bus_write(A_IRQ, 32'd1);
        check("irq_cleared", 32'(irq), 32'd0);
        start_frame(32'h1000);
        finish_frame(4, 1'b0);
        read_check("status_frame3", A_STAT, exp_status(1, 0, 1, 1, 0));
        bus_write(A_IRQ, 32'd1);

        // Run cleared mid-frame on buffer 1, then restart at BASE.
        start_frame(32'h1010);
        give_acks(2);
        bus_write(A_CTRL, 32'h2);
        check("stop_wr_enable", 32'(wr_enable), 32'd0);
        read_check("status_stopped", A_STAT, exp_status(1, 0, 1, 0, 0));
        check("stop_no_irq", 32'(irq), 32'd0);
        bus_write(A_CTRL, 32'h3);
        check("rerun_adr", wr_start_adr, 32'h1000);
        read_check("status_rerun", A_STAT, exp_status(0, 0, 1, 1, 0));

        // Short frame: drop counted, same buffer rearmed.
        start_frame(32'h1000);
        give_acks(2);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("short_arm_wr_enable", 32'(wr_enable), 32'd0);
        check("short_arm_adr", wr_start_adr, 32'h1000);
        @(negedge clk);
        check("short_run_wr_enable", 32'(wr_enable), 32'd1);
        read_check("status_short", A_STAT, exp_status(0, 0, 1, 3, 1));
        finish_frame(4, 1'b0);
        read_check("status_short_done", A_STAT, exp_status(1, 0, 1, 1, 1));

        // Three buffers with buffer 1 locked.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_IRQ, 32'd1);
        bus_write(A_NB, 32'd3);
        bus_write(A_LOCK, 32'd1);
        bus_write(A_CTRL, 32'h7);
        for (int i = 0; i < 4; i++) begin
            start_frame(lock_adr[i]);
            finish_frame(4, 1'b0);
            read_check($sformatf("lock_status%0d", i), A_STAT,
                       exp_status(lock_cur[i], lock_last[i], 1, 1, 1));
        end
        check("lock_irq", 32'(irq), 32'd1);

        // Asynchronous reset in the middle of a frame.
        start_frame(32'h1000);
        give_acks(1);
        rst = 1'b1;
        #1;
        check("rst_wr_enable", 32'(wr_enable), 32'd0);
        check("rst_start_adr", wr_start_adr, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_check("rst_ctrl", A_CTRL, 32'h0);
        read_check("rst_base", A_BASE, 32'h0);
        read_check("rst_status", A_STAT, 32'h0);

        // FRAME_WORDS=0 blocks the run; NUM_BUFS=0 behaves as a single buffer.
        bus_write(A_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        read_check("fw0_idle", A_STAT, 32'h0);
        bus_write(A_BASE, 32'h2000);
        bus_write(A_FW, 32'd4);
        start_frame(32'h2000);
        finish_frame(4, 1'b0);
        read_check("nb0_status", A_STAT, exp_status(0, 0, 1, 1, 0));
        start_frame(32'h2000);
        finish_frame(4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
